// File: rtl/syscall_run_ctrl_if.sv
// Core-side bundle for syscall_run_ctrl: syscall decode and run-control inputs,
// PC enable, status, print history and counter outputs.
interface syscall_run_ctrl_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned HIST_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned SEL_W = $clog2(HIST_DEPTH);

    logic              syscall_valid;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              resume;
    logic              step_mode;
    logic              step_pulse;
    logic [SEL_W-1:0]  hist_sel;
    logic              pc_en;
    logic              halted;
    logic              paused;
    logic [DATA_W-1:0] display;
    logic [DATA_W-1:0] hist_data;
    logic [SEL_W:0]    hist_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output syscall_valid, v0, a0, resume, step_mode, step_pulse, hist_sel,
        input  pc_en, halted, paused, display, hist_data, hist_count,
               cycle_count, instr_count
    );

    modport slave (
        input  syscall_valid, v0, a0, resume, step_mode, step_pulse, hist_sel,
        output pc_en, halted, paused, display, hist_data, hist_count,
               cycle_count, instr_count
    );
endinterface

// File: rtl/syscall_run_ctrl.sv
// Run-control / syscall service unit: halt, pause/resume, print history and counters.
// Single-step support is built only when SYSCALL_STEP_EN is defined.
module syscall_run_ctrl #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       HIST_DEPTH = 8,
    parameter int unsigned       CNT_W      = 32,
    parameter logic [DATA_W-1:0] HALT_CODE  = 10,
    parameter logic [DATA_W-1:0] PAUSE_CODE = 50
) (
    input logic               clk,
    input logic               rst_n,
    syscall_run_ctrl_if.slave bus
);
    localparam int unsigned    PTR_W     = $clog2(HIST_DEPTH);
    localparam logic [PTR_W:0] HIST_FULL = (PTR_W+1)'(HIST_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_PAUSE, S_HALT} state_t;

    state_t            state_q, state_d;
    logic              resume_q;
    logic              resume_edge;
    logic              adv;
    logic              halt_req, pause_req, print_req;
    logic              pc_en;
    logic              hist_wr;
    logic [DATA_W-1:0] display_q;
    logic [DATA_W-1:0] hist_q [HIST_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W:0]    hist_count_q;
    logic [CNT_W-1:0]  cycle_q, instr_q;

    assign resume_edge = bus.resume & ~resume_q;
    assign halt_req    = bus.syscall_valid && (bus.v0 == HALT_CODE);
    assign pause_req   = bus.syscall_valid && (bus.v0 == PAUSE_CODE);
    assign print_req   = bus.syscall_valid && !halt_req && !pause_req;

`ifdef SYSCALL_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= bus.step_pulse;
    end

    assign adv = !bus.step_mode || (bus.step_pulse && !step_q);
`else
    logic unused_step;

    assign unused_step = bus.step_mode ^ bus.step_pulse;
    assign adv         = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= bus.resume;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt_req)       state_d = S_HALT;
                else if (pause_req) state_d = S_PAUSE;
            end
            S_PAUSE: if (resume_edge) state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // The resume-edge cycle in PAUSE enables the PC so it steps past the held syscall.
    always_comb begin
        pc_en   = 1'b0;
        hist_wr = 1'b0;
        case (state_q)
            S_RUN: begin
                pc_en   = !halt_req && !pause_req && adv;
                hist_wr = print_req && pc_en;
            end
            S_PAUSE: pc_en = resume_edge;
            default: pc_en = 1'b0;
        endcase
        if (!rst_n) begin
            pc_en   = 1'b0;
            hist_wr = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q    <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            cycle_q      <= '0;
            instr_q      <= '0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            if (hist_wr) begin
                display_q        <= bus.a0;
                hist_q[wr_ptr_q] <= bus.a0;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                if (hist_count_q != HIST_FULL) hist_count_q <= hist_count_q + (PTR_W+1)'(1);
            end
            if (state_q != S_HALT && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
            if (pc_en && instr_q != '1)             instr_q <= instr_q + CNT_W'(1);
        end
    end

    // Index wraps modulo HIST_DEPTH because the pointer width is exactly log2(HIST_DEPTH).
    assign rd_idx        = wr_ptr_q - PTR_W'(1) - bus.hist_sel;
    assign bus.hist_data = ({1'b0, bus.hist_sel} < hist_count_q) ? hist_q[rd_idx] : '0;

    assign bus.pc_en       = pc_en;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.paused      = (state_q == S_PAUSE);
    assign bus.display     = display_q;
    assign bus.hist_count  = hist_count_q;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;
endmodule

// File: tb/tb_syscall_run_ctrl.sv
// Directed bench for syscall_run_ctrl with a scoreboard of expected results;
// a second instance with 4-bit counters exercises counter saturation.
module tb_syscall_run_ctrl;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned HIST_DEPTH = 8;
    localparam int unsigned CNT_W      = 32;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;

    exp_t exp_q [$];
    logic pc_q  [$];
    int   errors = 0;
    int   checks = 0;
    int   m_cyc  = 0;
    int   m_instr = 0;

    always #10 clk = ~clk;

    syscall_run_ctrl_if #(.DATA_W(DATA_W), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)) bus ();
    syscall_run_ctrl_if #(.DATA_W(DATA_W), .HIST_DEPTH(HIST_DEPTH), .CNT_W(4))     bus2 ();

    syscall_run_ctrl #(.DATA_W(DATA_W), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    syscall_run_ctrl #(.DATA_W(DATA_W), .HIST_DEPTH(HIST_DEPTH), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One cycle: check pc_en against exp_pc before the edge, then advance the model counters.
    task automatic step(input string tag, input logic exp_pc, input logic counts_cyc);
        logic e;
        pc_q.push_back(exp_pc);
        #1;
        checks++;
        e = pc_q.pop_front();
        assert (bus.pc_en === e) else begin
            errors++;
            $error("FAIL %s: observed %0b required %0b", tag, bus.pc_en, e);
        end
        @(posedge clk);
        #1;
        if (counts_cyc) m_cyc++;
        if (exp_pc)     m_instr++;
    endtask

    task automatic chk_cnt(input string tag);
        push_exp({tag, "_cycle_count"}, 64'(m_cyc));
        got(64'(bus.cycle_count));
        push_exp({tag, "_instr_count"}, 64'(m_instr));
        got(64'(bus.instr_count));
    endtask

    initial begin
        bus.syscall_valid  = 1'b0;
        bus.v0             = '0;
        bus.a0             = '0;
        bus.resume         = 1'b0;
        bus.step_mode      = 1'b0;
        bus.step_pulse     = 1'b0;
        bus.hist_sel       = '0;
        bus2.syscall_valid = 1'b0;
        bus2.v0            = '0;
        bus2.a0            = '0;
        bus2.resume        = 1'b0;
        bus2.step_mode     = 1'b0;
        bus2.step_pulse    = 1'b0;
        bus2.hist_sel      = '0;

        @(posedge clk);
        #1;
        push_exp("rst_pc_en", 0);      got(64'(bus.pc_en));
        push_exp("rst_halted", 0);     got(64'(bus.halted));
        push_exp("rst_paused", 0);     got(64'(bus.paused));
        push_exp("rst_display", 0);    got(64'(bus.display));
        push_exp("rst_hist_count", 0); got(64'(bus.hist_count));
        chk_cnt("rst");
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // print then halt
        step("idle_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b1; bus.v0 = 1; bus.a0 = 32'h1234;
        push_exp("print_display", 64'h1234);
        push_exp("print_hist_count", 1);
        push_exp("print_hist0", 64'h1234);
        step("print_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b0;
        got(64'(bus.display));
        got(64'(bus.hist_count));
        got(64'(bus.hist_data));
        chk_cnt("print");

        bus.syscall_valid = 1'b1; bus.v0 = 10; bus.a0 = 32'hdead;
        push_exp("halt_halted", 1);
        step("halt_pc", 1'b0, 1'b1);
        got(64'(bus.halted));
        bus.v0 = 1; bus.a0 = 32'hbeef;
        repeat (3) step("halt_hold_pc", 1'b0, 1'b0);
        push_exp("halt_display", 64'h1234); got(64'(bus.display));
        chk_cnt("halt");

        // reset out of HALT
        rst_n = 1'b0;
        #1;
        bus.syscall_valid = 1'b0;
        m_cyc = 0; m_instr = 0;
        push_exp("rst_halt_halted", 0);  got(64'(bus.halted));
        push_exp("rst_halt_display", 0); got(64'(bus.display));
        push_exp("rst_halt_pc_en", 0);   got(64'(bus.pc_en));
        chk_cnt("rst_halt");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_pc", 1'b1, 1'b1);

        // print 0x55, then pause with resume already high
        bus.syscall_valid = 1'b1; bus.v0 = 4; bus.a0 = 32'h55;
        push_exp("p55_display", 64'h55);
        step("p55_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b0;
        got(64'(bus.display));
        bus.resume = 1'b1;
        step("run_resume_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b1; bus.v0 = 50; bus.a0 = 32'h77;
        push_exp("pause_paused", 1);
        step("pause_pc", 1'b0, 1'b1);
        got(64'(bus.paused));
        repeat (3) step("pause_level_pc", 1'b0, 1'b1);
        bus.resume = 1'b0;
        step("pause_low_pc", 1'b0, 1'b1);
        bus.resume = 1'b1;
        push_exp("resume_paused", 0);
        push_exp("resume_display", 64'h55);
        step("resume_edge_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b0;
        got(64'(bus.paused));
        got(64'(bus.display));
        chk_cnt("resume");
        step("after_resume_pc", 1'b1, 1'b1);

        // pause entry coinciding with a resume edge: resume must be ignored
        bus.resume = 1'b0;
        step("idle2_pc", 1'b1, 1'b1);
        bus.syscall_valid = 1'b1; bus.v0 = 50; bus.resume = 1'b1;
        step("pause2_pc", 1'b0, 1'b1);
        step("pause2_noedge_pc", 1'b0, 1'b1);

        // reset mid-PAUSE with display 0x55
        rst_n = 1'b0;
        #1;
        bus.syscall_valid = 1'b0; bus.resume = 1'b0;
        m_cyc = 0; m_instr = 0;
        push_exp("rst_pause_paused", 0);     got(64'(bus.paused));
        push_exp("rst_pause_display", 0);    got(64'(bus.display));
        push_exp("rst_pause_hist_count", 0); got(64'(bus.hist_count));
        chk_cnt("rst_pause");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst2_pc", 1'b1, 1'b1);

        // history wrap: prints 1..10
        for (int i = 1; i <= 10; i++) begin
            bus.syscall_valid = 1'b1; bus.v0 = 1; bus.a0 = i;
            step("hist_print_pc", 1'b1, 1'b1);
            if (i == 3) begin
                bus.hist_sel = 3;
                push_exp("hist_sel_oor", 0);
                #1; got(64'(bus.hist_data));
                bus.hist_sel = 2;
                push_exp("hist_sel2_early", 1);
                #1; got(64'(bus.hist_data));
            end
        end
        bus.syscall_valid = 1'b0;
        push_exp("hist_count_sat", 8); got(64'(bus.hist_count));
        push_exp("hist_display", 10);  got(64'(bus.display));
        bus.hist_sel = 0; push_exp("hist_sel0", 10); #1; got(64'(bus.hist_data));
        bus.hist_sel = 1; push_exp("hist_sel1", 9);  #1; got(64'(bus.hist_data));
        bus.hist_sel = 7; push_exp("hist_sel7", 3);  #1; got(64'(bus.hist_data));
        bus.hist_sel = 0;
        chk_cnt("hist");

`ifdef SYSCALL_STEP_EN
        bus.step_mode = 1'b1; bus.step_pulse = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.step_pulse = ((c >= 2 && c < 5) || (c >= 8 && c < 10) || (c >= 14 && c < 17));
            step("step_pc", (c == 2 || c == 8 || c == 14), 1'b1);
        end
        chk_cnt("step");
        bus.syscall_valid = 1'b1; bus.v0 = 10;
        push_exp("step_halted", 1);
        step("step_halt_pc", 1'b0, 1'b1);
        got(64'(bus.halted));
        bus.syscall_valid = 1'b0;
`else
        bus.step_mode = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.step_pulse = c[0];
            step("nostep_pc", 1'b1, 1'b1);
        end
        chk_cnt("nostep");
`endif

        // 4-bit counters have been running far longer than 15 cycles
        push_exp("sat_cycle_count", 15); got(64'(bus2.cycle_count));
        push_exp("sat_instr_count", 15); got(64'(bus2.instr_count));
        repeat (3) @(posedge clk);
        #1;
        push_exp("sat_cycle_held", 15); got(64'(bus2.cycle_count));

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
